apb_master_arbiter: RTL

//  Two-requester APB master. Arbitrates requesters 0 and 1 round-robin onto one APB bus.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_rr_arb2.sv | 21 ++
 rtl/apb_master_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared state encoding and default sizing for the two-requester APB master.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int ADDR_W_DEF  = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    // A zero timeout still needs a one-bit counter so the register is never zero-width.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last.
module apb_rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// bounded wait states and per-requester response registers.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET_n,

    input  logic              rq0_valid_i,
    input  logic              rq0_write_i,
    input  logic [ADDR_W-1:0] rq0_addr_i,
    input  logic [DATA_W-1:0] rq0_wdata_i,
    output logic              rq0_ack_o,
    output logic              rq0_done_o,
    output logic [DATA_W-1:0] rq0_rdata_o,
    output logic              rq0_err_o,

    input  logic              rq1_valid_i,
    input  logic              rq1_write_i,
    input  logic [ADDR_W-1:0] rq1_addr_i,
    input  logic [DATA_W-1:0] rq1_wdata_i,
    output logic              rq1_ack_o,
    output logic              rq1_done_o,
    output logic [DATA_W-1:0] rq1_rdata_o,
    output logic              rq1_err_o,

    output logic              PSEL_o,
    output logic              PENABLE_o,
    output logic              PWRITE_o,
    output logic [ADDR_W-1:0] PADDR_o,
    output logic [DATA_W-1:0] PWDATA_o,
    input  logic [DATA_W-1:0] PRDATA_i,
    input  logic              PREADY_i,
    input  logic              PSLVERR_i,

    output logic              busy_o
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t        state;
    logic              last_grant;   // also identifies the owner of the transfer in flight
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        grant;
    logic              timed_out;
    logic              finish;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    apb_rr_arb2 u_rr_arb (
        .valid      ({rq1_valid_i, rq0_valid_i}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // A slave that answers on the timeout cycle still wins: PREADY takes priority.
    always_comb begin
        timed_out  = (TIMEOUT != 0) && !PREADY_i && (wait_cnt == CNT_LAST);
        finish     = (state == ACCESS) && (PREADY_i || timed_out);
        resp_rdata = '0;
        resp_err   = 1'b1;
        if (PREADY_i) begin
            resp_rdata = PWRITE_o ? '0 : PRDATA_i;
            resp_err   = PSLVERR_i;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            PWRITE_o    <= 1'b0;
            PADDR_o     <= '0;
            PWDATA_o    <= '0;
            busy_o      <= 1'b0;
            rq0_ack_o   <= 1'b0;
            rq0_done_o  <= 1'b0;
            rq0_rdata_o <= '0;
            rq0_err_o   <= 1'b0;
            rq1_ack_o   <= 1'b0;
            rq1_done_o  <= 1'b0;
            rq1_rdata_o <= '0;
            rq1_err_o   <= 1'b0;
        end else begin
            rq0_ack_o  <= 1'b0;
            rq1_ack_o  <= 1'b0;
            rq0_done_o <= 1'b0;
            rq1_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        state      <= SETUP;
                        busy_o     <= 1'b1;
                        PSEL_o     <= 1'b1;
                        PENABLE_o  <= 1'b0;
                        last_grant <= grant[1];
                        PWRITE_o   <= grant[1] ? rq1_write_i : rq0_write_i;
                        PADDR_o    <= grant[1] ? rq1_addr_i  : rq0_addr_i;
                        PWDATA_o   <= grant[1] ? rq1_wdata_i : rq0_wdata_i;
                        rq0_ack_o  <= grant[0];
                        rq1_ack_o  <= grant[1];
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    PENABLE_o <= 1'b1;
                    wait_cnt  <= '0;
                end
                ACCESS: begin
                    if (finish) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        PSEL_o    <= 1'b0;
                        PENABLE_o <= 1'b0;
                        if (last_grant) begin
                            rq1_done_o  <= 1'b1;
                            rq1_rdata_o <= resp_rdata;
                            rq1_err_o   <= resp_err;
                        end else begin
                            rq0_done_o  <= 1'b1;
                            rq0_rdata_o <= resp_rdata;
                            rq0_err_o   <= resp_err;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    PSEL_o    <= 1'b0;
                    PENABLE_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
